// File: rtl/pingpang_pkg.sv
// Shared constants and state encoding for the ping-pong buffer read controller.
package pingpang_pkg;

  localparam int DEF_DW    = 16;
  localparam int DEF_AW    = 3;
  localparam int DEF_DEPTH = 1 << DEF_AW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_FLUSH
  } rd_state_e;

endpackage

// File: rtl/pingpang_rd_ctrl_if.sv
// Buffer read port plus downstream valid/ready stream of the read controller.
interface pingpang_rd_ctrl_if
  import pingpang_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
);

  logic [AW-1:0] addr_rd;
  logic [DW-1:0] buf_data;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  modport master (
    output addr_rd, m_data, m_valid, m_last,
    input  buf_data, m_ready
  );

  modport slave (
    input  addr_rd, m_data, m_valid, m_last,
    output buf_data, m_ready
  );

endinterface

// File: rtl/pingpang_out_stage.sv
// Valid/ready output register: captures a fetched word whenever the slot is free
// or being consumed, and holds steady under backpressure.
module pingpang_out_stage #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch,
  input  logic [DW-1:0] d_in,
  input  logic          last_in,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  output logic          m_last,
  output logic          load
);

  assign load = !m_valid || m_ready;

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously;
  // blocking here would let downstream logic see half-updated values within the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (load) begin
      if (fetch) begin
        m_data  <= d_in;
        m_valid <= 1'b1;
        m_last  <= last_in;
      end else begin
        // Nothing left to fetch: the word just consumed empties the slot.
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pingpang_rd_ctrl.sv
// Ping-pong buffer read controller: sweeps a released bank out as a stream and
// gates bank switches. Optional sticky ovr_err under PINGPANG_RD_OVR_EN.
module pingpang_rd_ctrl
  import pingpang_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int DEPTH = 1 << AW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic switch_in,
  output logic sw_ready,
  output logic bank_done,
  pingpang_rd_ctrl_if.master rd
`ifdef PINGPANG_RD_OVR_EN
  ,
  output logic ovr_err
`endif
);

  rd_state_e     state, state_nxt;
  logic [AW-1:0] addr_nxt;
  logic          done_nxt;
  logic          load;
  logic          at_last;
  logic          accept;

  assign at_last  = (rd.addr_rd == AW'(DEPTH - 1));
  assign sw_ready = (state == ST_IDLE) || (state == ST_FLUSH && rd.m_ready);
  assign accept   = switch_in && sw_ready;

  pingpang_out_stage #(.DW(DW)) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .fetch   (state == ST_READ),
    .d_in    (rd.buf_data),
    .last_in (at_last),
    .m_ready (rd.m_ready),
    .m_data  (rd.m_data),
    .m_valid (rd.m_valid),
    .m_last  (rd.m_last),
    .load    (load)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    addr_nxt  = rd.addr_rd;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_READ;
          addr_nxt  = '0;
        end
      end
      ST_READ: begin
        if (load) begin
          if (at_last) begin
            state_nxt = ST_FLUSH;
            addr_nxt  = '0;
          end else begin
            addr_nxt = rd.addr_rd + AW'(1);
          end
        end
      end
      ST_FLUSH: begin
        // The last word is the only one in flight; its handshake ends the bank.
        if (rd.m_valid && rd.m_ready) begin
          done_nxt  = 1'b1;
          addr_nxt  = '0;
          state_nxt = accept ? ST_READ : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rd.addr_rd <= '0;
      bank_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd.addr_rd <= addr_nxt;
      bank_done  <= done_nxt;
    end
  end

`ifdef PINGPANG_RD_OVR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_err <= 1'b0;
    end else if (switch_in && !sw_ready) begin
      ovr_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pingpang_rd_ctrl.sv
// Self-checking bench for pingpang_rd_ctrl with a behavioural two-bank buffer and
// a scoreboard of expected stream words.
module tb_pingpang_rd_ctrl;
  import pingpang_pkg::*;

  localparam int DW    = DEF_DW;
  localparam int AW    = DEF_AW;
  localparam int DEPTH = DEF_DEPTH;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic switch_in;
  logic sw_ready;
  logic bank_done;
`ifdef PINGPANG_RD_OVR_EN
  logic ovr_err;
`endif

  pingpang_rd_ctrl_if #(.DW(DW), .AW(AW)) rd ();

  pingpang_rd_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .switch_in (switch_in),
    .sw_ready  (sw_ready),
    .bank_done (bank_done),
    .rd        (rd)
`ifdef PINGPANG_RD_OVR_EN
    ,
    .ovr_err   (ovr_err)
`endif
  );

  always #5 clk = ~clk;

  // Buffer model: writer owns wr_bank, reader sees the other bank combinationally.
  logic [DW-1:0] mem [2][DEPTH];
  logic          wr_bank = 1'b0;
  assign rd.buf_data = mem[~wr_bank][rd.addr_rd];
  always @(posedge clk) if (switch_in && sw_ready) wr_bank <= ~wr_bank;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  int   hs_log[$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   sw_edge  = 0;
  bit   bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge what the next rising edge will see.
  logic [DW-1:0] prev_data;
  logic          prev_last;
  bit            prev_stall  = 0;
  bit            expect_done = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall  = 0;
      expect_done = 0;
    end else begin
      if (bank_done || expect_done) begin
        check("bank_done", bank_done, expect_done);
        if (bank_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
      expect_done = 0;
      if (prev_stall) begin
        check("stall_data", rd.m_data, prev_data);
        check("stall_valid", rd.m_valid, 1);
        check("stall_last", rd.m_last, prev_last);
      end
      if (rd.m_valid && rd.m_ready) begin
        check("sb_occupancy", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("word", rd.m_data, e.data);
          check("last", rd.m_last, e.last);
          expect_done = e.last;
          hs_log.push_back(cyc + 1);
        end
      end
      prev_stall = rd.m_valid && !rd.m_ready;
      prev_data  = rd.m_data;
      prev_last  = rd.m_last;
    end
  end

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) mem[wr_bank][i] = base + DW'(i);
  endtask

  task automatic push_bank(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++)
      sb.push_back(exp_t'{data: base + DW'(i), last: (i == DEPTH - 1)});
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 of edge N (sw_edge).
  task automatic pulse_switch(input bit legal, input logic [DW-1:0] base);
    switch_in = 1'b1;
    if (legal) push_bank(base);
    @(posedge clk);
    #1;
    sw_edge   = cyc;
    switch_in = 1'b0;
  endtask

  task automatic run_until_done(input int target, input bit bp);
    int k;
    k = 0;
    while (done_cnt < target && k < 200) begin
      rd.m_ready = bp ? bp_pat[k % 4] : 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    check("done_count", done_cnt, target);
    rd.m_ready = 1'b1;
  endtask

  initial begin
    int k;
    int l_edge;
    rst_n      = 1'b1;
    switch_in  = 1'b0;
    rd.m_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_data", rd.m_data, 0);
    check("rst_m_valid", rd.m_valid, 0);
    check("rst_m_last", rd.m_last, 0);
    check("rst_addr_rd", rd.addr_rd, 0);
    check("rst_bank_done", bank_done, 0);
    check("rst_sw_ready", sw_ready, 1);
`ifdef PINGPANG_RD_OVR_EN
    check("rst_ovr_err", ovr_err, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single bank, no backpressure.
    fill(16'h1000);
    hs_log.delete();
    pulse_switch(1, 16'h1000);
    check("t1_addr_start", rd.addr_rd, 0);
    check("t1_valid_n1", rd.m_valid, 0);
    run_until_done(1, 0);
    check("t1_hs_count", hs_log.size(), DEPTH);
    if (hs_log.size() == DEPTH) begin
      check("t1_first_edge", hs_log[0], sw_edge + 2);
      check("t1_last_edge", hs_log[DEPTH-1], sw_edge + 1 + DEPTH);
    end
    check("t1_done_edge", done_cyc + 1, sw_edge + 2 + DEPTH);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure 1,0,0,1...
    fill(16'h1000);
    hs_log.delete();
    pulse_switch(1, 16'h1000);
    run_until_done(2, 1);
    check("t2_hs_count", hs_log.size(), DEPTH);

    // Back-to-back banks, second switch in the final-handshake cycle.
    fill(16'h1000);
    hs_log.delete();
    pulse_switch(1, 16'h1000);
    fill(16'h2000);
    for (k = 0; k < 50 && !(rd.m_valid && rd.m_last); k++) begin
      @(posedge clk);
      #1;
    end
    check("t3_reach_last", rd.m_valid && rd.m_last, 1);
    check("t3_sw_ready_final", sw_ready, 1);
    switch_in = 1'b1;
    push_bank(16'h2000);
    @(posedge clk);
    #1;
    l_edge    = cyc;
    switch_in = 1'b0;
    run_until_done(4, 0);
    check("t3_hs_count", hs_log.size(), 2 * DEPTH);
    if (hs_log.size() == 2 * DEPTH) begin
      check("t3_final_hs_edge", hs_log[DEPTH-1], l_edge);
      check("t3_one_bubble", hs_log[DEPTH], l_edge + 2);
    end

    // Illegal switch mid-READ at word 3.
`ifdef PINGPANG_RD_OVR_EN
    check("t4_ovr_before", ovr_err, 0);
`endif
    fill(16'h1000);
    hs_log.delete();
    pulse_switch(1, 16'h1000);
    for (k = 0; k < 50 && !(rd.m_valid && rd.m_data == 16'h1003); k++) begin
      @(posedge clk);
      #1;
    end
    check("t4_reach_word3", rd.m_data, 16'h1003);
    check("t4_sw_ready_mid", sw_ready, 0);
    pulse_switch(0, 16'h0);
`ifdef PINGPANG_RD_OVR_EN
    check("t4_ovr_set", ovr_err, 1);
`endif
    run_until_done(5, 0);
    check("t4_hs_count", hs_log.size(), DEPTH);
    repeat (3) @(posedge clk);
    #1;
`ifdef PINGPANG_RD_OVR_EN
    check("t4_ovr_sticky", ovr_err, 1);
`endif

    // Reset after word 4 has handshaked.
    fill(16'h1000);
    hs_log.delete();
    pulse_switch(1, 16'h1000);
    for (k = 0; k < 50 && hs_log.size() < 5; k++) begin
      @(posedge clk);
      #1;
    end
    check("t5_reach_word4", hs_log.size(), 5);
    rd.m_ready = 1'b0;
    rst_n      = 1'b0;
    #1;
    sb.delete();
    check("t5_m_data", rd.m_data, 0);
    check("t5_m_valid", rd.m_valid, 0);
    check("t5_m_last", rd.m_last, 0);
    check("t5_addr_rd", rd.addr_rd, 0);
    check("t5_bank_done", bank_done, 0);
    check("t5_sw_ready", sw_ready, 1);
`ifdef PINGPANG_RD_OVR_EN
    check("t5_ovr_cleared", ovr_err, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    rd.m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt, 5);
    fill(16'h5000);
    hs_log.delete();
    pulse_switch(1, 16'h5000);
    check("t5_restart_addr", rd.addr_rd, 0);
    run_until_done(6, 0);
    check("t5_hs_count", hs_log.size(), DEPTH);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pingpang_rd_ctrl.md
# pingpang_rd_ctrl

Read-side controller for the single-channel ping-pong buffer. On each bank switch it sweeps the buffer read address over the newly released bank and delivers the words in order as a valid/ready stream, with a last marker on the final word. It drives the buffer's `addr_rd`, samples its `data_out`, and gates when the write side may switch banks again, so downstream backpressure cannot corrupt a bank that is still being drained.

## Interface
- `DW`, 16: data width; equals the buffer word width.
- `AW`, 3: read address width.
- `DEPTH`, 8: words per bank; must equal 2**AW.
- `clk`  in  1: single clock, shared with the buffer.
- `rst_n`  in  1: asynchronous, active-low reset.
- `switch_in`  in  1: one-cycle pulse, the same pulse that toggles the buffer bank select.
- `sw_ready`  out  1: combinational; high when a `switch_in` this cycle is legal.
- `addr_rd`  out  AW: registered read address to the buffer.
- `buf_data`  in  DW: the buffer's `data_out`, which is a combinational function of `addr_rd`.
- `m_data`  out  DW: stream data.
- `m_valid`  out  1: stream valid.
- `m_ready`  in  1: stream ready from the downstream block.
- `m_last`  out  1: marks word DEPTH-1 of the bank.
- `bank_done`  out  1: one-cycle pulse, the cycle after the last word handshakes.

## Operation
- States:
  - IDLE: no bank to read.
  - READ: fetching words.
  - FLUSH: all words fetched, waiting for the last word to handshake.
- `load = !m_valid || m_ready`. The output register captures only when `load` is high.
- IDLE: on `switch_in`, go to READ with `addr_rd=0`.
- READ, when `load` is high:
  - `m_data <= buf_data`, `m_valid <= 1`.
  - `m_last <= (addr_rd == DEPTH-1)`.
  - If `addr_rd == DEPTH-1`, go to FLUSH with `addr_rd <= 0`. Otherwise `addr_rd <= addr_rd+1`.
- READ, when `load` is low: hold the address and the output register.
- FLUSH:
  - When `m_valid && m_ready`: `m_valid <= 0` and `bank_done` pulses on the next cycle.
  - Then go to IDLE, or directly to READ at `addr_rd=0` if `switch_in` arrives in that same cycle.
- `sw_ready = (state==IDLE) || (state==FLUSH && m_ready)`.
- A `switch_in` with `sw_ready` low is illegal. It is ignored: no state change, no restart. See Configuration for optional error reporting.
- Address arithmetic is AW bits, wrapping from DEPTH-1 to 0. No other wrap is permitted.
- The read bank is stable throughout READ/FLUSH because the writer honours `sw_ready`.

## Timing
- All outputs reset to 0: `m_data`, `m_valid`, `m_last`, `addr_rd`, `bank_done` (and `ovr_err` when compiled in). The state resets to IDLE.
- Reset mid-bank aborts immediately. In-flight words are discarded and `bank_done` is not issued.
- `switch_in` sampled at edge N:
  - READ with `addr_rd=0` from N+1.
  - Word 0 on `m_data` with `m_valid` from N+2.
- With `m_ready` held high: one word per cycle. `m_last` is on cycle N+1+DEPTH; `bank_done` follows one cycle later.
- Back-to-back banks: a switch accepted in the final-handshake cycle gives exactly one bubble cycle between banks.
- `m_data`, `m_valid` and `m_last` hold steady while `m_valid && !m_ready`.

## Configuration
- `PINGPANG_RD_OVR_EN` defined:
  - Adds output `ovr_err` (1 bit), which is sticky.
  - It sets on the cycle after any `switch_in` while `sw_ready` is low, and clears only on reset.
- Not defined: the `ovr_err` port and its logic are absent, and illegal switches are silently ignored.
- Stream behaviour is identical in both builds.

## Structure
- Package `pingpang_pkg`:
  - default `DW`/`AW` constants;
  - state enum (`ST_IDLE`, `ST_READ`, `ST_FLUSH`);
  - `DEPTH` derived as `1<<AW`.
- One sub-module is natural: `pingpang_out_stage`. It holds the valid/ready output register (`m_data`/`m_valid`/`m_last`, `load` generation).
- The FSM and address counter stay in `pingpang_rd_ctrl`.
- The bench instantiates `pingpang_rd_ctrl` together with the existing buffer. `switch_in` feeds both the buffer's `switch` and this block.

## Test plan
- **Single bank, no backpressure:** fill the bank with 0x1000..0x1007, pulse `switch_in` at edge N with `m_ready=1` -> words 0x1000..0x1007 on edges N+2..N+9, `m_last` only on 0x1007, `bank_done` pulse at N+10.
- **Backpressure:** `m_ready` toggles 1,0,0,1,… -> the same 8 words in order with no loss or duplication; `m_data` is stable during every stall.
- **Back-to-back banks:** second bank 0x2000..0x2007, `switch_in` in the final-handshake cycle -> the second bank starts after exactly one bubble; `sw_ready` is high in that cycle.
- **Illegal switch:** `switch_in` mid-READ at word 3 -> the sweep continues to 0x1007 unchanged; with `PINGPANG_RD_OVR_EN`, `ovr_err` is 1 from the next cycle until reset.
- **Reset mid-operation:** assert `rst_n=0` after word 4 -> all outputs 0 and state IDLE immediately; no `bank_done`; a later switch restarts at `addr_rd=0`.
- **Reset values:** check all outputs are 0 and `sw_ready=1` out of reset.
